// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared states, default widths and saturating add for the PE MAC stage
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pe_state_e;

    localparam int IF_WIDTH_DEF          = 16;
    localparam int FILTER_WIDTH_DEF      = 16;
    localparam int FILTER_ADDR_WIDTH_DEF = 4;
    localparam int PSUM_WIDTH_DEF        = 40;
    localparam int PSUM_FIFO_DEPTH_DEF   = 4;
    localparam int PSUM_CNT_WIDTH_DEF    = 3;

    // Operands arrive sign-extended to 64 bits; w must be <= 63 so the raw sum cannot overflow.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] sum;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sum   = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// rtl/psum_fifo.sv - first-word fall-through psum FIFO with occupancy count
module psum_fifo #(
    parameter int WIDTH     = 40,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic                 head_valid,
    output logic [CNT_WIDTH-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 pop_ok;
    logic                 push_ok;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop & (count_q != '0);
    assign push_ok = push & ((count_q != FULL_CNT) | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/pe_mac_accumulator.sv
// rtl/pe_mac_accumulator.sv - PE multiply-accumulate into psum FIFO; PE_PSUM_SAT_EN enables saturation
module pe_mac_accumulator
    import pe_pkg::*;
#(
    parameter int IF_WIDTH          = IF_WIDTH_DEF,
    parameter int FILTER_WIDTH      = FILTER_WIDTH_DEF,
    parameter int FILTER_ADDR_WIDTH = FILTER_ADDR_WIDTH_DEF,
    parameter int PSUM_WIDTH        = PSUM_WIDTH_DEF,
    parameter int PSUM_FIFO_DEPTH   = PSUM_FIFO_DEPTH_DEF,
    parameter int PSUM_CNT_WIDTH    = PSUM_CNT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [FILTER_ADDR_WIDTH-1:0] filter_size,
    input  logic                         in_step,
    input  logic                         in_valid,
    input  logic [IF_WIDTH-1:0]          in_if,
    input  logic [FILTER_WIDTH-1:0]      in_filter,
    input  logic                         in_done,
    output logic                         stall,
    output logic [PSUM_WIDTH-1:0]        psum_data,
    output logic                         psum_valid,
    input  logic                         psum_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         partial_err
);
    localparam int PROD_W = IF_WIDTH + FILTER_WIDTH;
    localparam logic [PSUM_CNT_WIDTH-1:0] STALL_LVL = PSUM_CNT_WIDTH'(PSUM_FIFO_DEPTH - 1);

    pe_state_e                      state_q, state_d;
    logic [FILTER_ADDR_WIDTH-1:0]   elem_cnt_q, elem_cnt_d;
    logic                           partial_err_q, partial_err_d;
    logic signed [PSUM_WIDTH-1:0]   acc_q, acc_d;
    logic                           s1_valid_q, s1_valid_d;
    logic signed [PSUM_WIDTH-1:0]   s1_prod_q, s1_prod_d;
    logic                           s1_first_q, s1_first_d;
    logic                           s1_last_q, s1_last_d;

    logic [FILTER_ADDR_WIDTH-1:0]   fs;
    logic [FILTER_ADDR_WIDTH-1:0]   elem_cnt_next;
    logic                           accept;
    logic                           is_last;
    logic signed [PROD_W-1:0]       prod_full;
    logic signed [PSUM_WIDTH-1:0]   acc_base;
    logic signed [PSUM_WIDTH-1:0]   acc_sum;
    logic                           fifo_push;
    logic [PSUM_CNT_WIDTH-1:0]      fifo_count;

    assign fs        = (filter_size == '0) ? FILTER_ADDR_WIDTH'(1) : filter_size;
    assign is_last   = (elem_cnt_q == fs - FILTER_ADDR_WIDTH'(1));
    assign stall     = (state_q == RUN) && (fifo_count >= STALL_LVL);
    assign accept    = (state_q == RUN) && in_step && !stall;
    assign prod_full = $signed(in_if) * $signed(in_filter);
    assign acc_base  = s1_first_q ? '0 : acc_q;

`ifdef PE_PSUM_SAT_EN
    assign acc_sum = PSUM_WIDTH'(sat_add(64'(acc_base), 64'(s1_prod_q), PSUM_WIDTH));
`else
    assign acc_sum = acc_base + s1_prod_q;
`endif

    always_comb begin
        state_d       = state_q;
        elem_cnt_d    = elem_cnt_q;
        partial_err_d = partial_err_q;
        acc_d         = acc_q;
        s1_valid_d    = 1'b0;
        s1_prod_d     = '0;
        s1_first_d    = 1'b0;
        s1_last_d     = 1'b0;
        fifo_push     = 1'b0;
        elem_cnt_next = elem_cnt_q;

        if (s1_valid_q) begin
            if (s1_last_q) begin
                fifo_push = 1'b1;
                acc_d     = '0;
            end else begin
                acc_d = acc_sum;
            end
        end

        if (accept) begin
            s1_valid_d    = 1'b1;
            s1_prod_d     = in_valid ? PSUM_WIDTH'(prod_full) : '0;
            s1_first_d    = (elem_cnt_q == '0);
            s1_last_d     = is_last;
            elem_cnt_next = is_last ? '0 : elem_cnt_q + FILTER_ADDR_WIDTH'(1);
            elem_cnt_d    = elem_cnt_next;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = RUN;
                    elem_cnt_d    = '0;
                    acc_d         = '0;
                    s1_valid_d    = 1'b0;
                    partial_err_d = 1'b0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // A step arriving with in_done is counted before the window check.
                if (in_done) begin
                    state_d    = DRAIN;
                    elem_cnt_d = '0;
                    if (elem_cnt_next != '0) begin
                        partial_err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!s1_valid_q && fifo_count == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            elem_cnt_q    <= '0;
            partial_err_q <= 1'b0;
            acc_q         <= '0;
            s1_valid_q    <= 1'b0;
            s1_prod_q     <= '0;
            s1_first_q    <= 1'b0;
            s1_last_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            elem_cnt_q    <= elem_cnt_d;
            partial_err_q <= partial_err_d;
            acc_q         <= acc_d;
            s1_valid_q    <= s1_valid_d;
            s1_prod_q     <= s1_prod_d;
            s1_first_q    <= s1_first_d;
            s1_last_q     <= s1_last_d;
        end
    end

    psum_fifo #(
        .WIDTH     (PSUM_WIDTH),
        .DEPTH     (PSUM_FIFO_DEPTH),
        .CNT_WIDTH (PSUM_CNT_WIDTH)
    ) u_psum_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_data  (acc_sum),
        .pop        (psum_ready),
        .head_data  (psum_data),
        .head_valid (psum_valid),
        .count      (fifo_count)
    );

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign partial_err = partial_err_q;

endmodule
